// File: rtl/icb_arb_pkg.sv
// Shared constants and helpers for the two-master ICB arbiter.
package icb_arb_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;

  // Master identifiers, as stored in the response-routing FIFO.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Width of a counter that must hold every value 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/icb_id_fifo.sv
// In-order FIFO of 1-bit master IDs: one entry per outstanding command,
// head tells the response channel which master the next response belongs to.
module icb_id_fifo
  import icb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer increment with explicit wrap so non-power-of-2 widths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // ID storage: write the pushed ID at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= {DEPTH{1'b0}};
    end else if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers advance independently on pop/push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/icb_arb2.sv
// Two-master to one-slave ICB arbiter: round-robin on the command channel,
// command locked while the slave stalls, responses routed in order by ID FIFO.
module icb_arb2
  import icb_arb_pkg::*;
#(
  parameter int AW         = ICB_AW,
  parameter int DW         = ICB_DW,
  parameter int OUTS_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [DW-1:0] m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [DW-1:0] m0_icb_rsp_rdata,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [DW-1:0] m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [DW-1:0] m1_icb_rsp_rdata,
  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic          o_icb_cmd_read,
  output logic [DW-1:0] o_icb_cmd_wdata,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic [DW-1:0] o_icb_rsp_rdata
);

  localparam int CW = cnt_width(OUTS_DEPTH);

  logic [1:0]    req_s;
  logic          gnt_s;
  logic          gnt_vld_s;
  logic          cmd_full_s;
  logic          cmd_hs_s;
  logic          rsp_hs_s;
  logic          head_s;
  logic          fifo_empty_s;
  logic [CW-1:0] count_s;
  logic          last_gnt_r;
  logic          lock_vld_r;
  logic          lock_id_r;

  assign req_s = {m1_icb_cmd_valid, m0_icb_cmd_valid};

  // Grant selection: a stalled command keeps its grant, otherwise round-robin.
  always_comb begin
    gnt_s = M0;
    if (lock_vld_r) begin
      gnt_s = lock_id_r;
    end else begin
      case (req_s)
        2'b01:   gnt_s = M0;
        2'b10:   gnt_s = M1;
        2'b11:   gnt_s = ~last_gnt_r;
        default: gnt_s = M0;
      endcase
    end
  end

  // Command mux; acceptance is gated on the registered FIFO count (no pop bypass).
  always_comb begin
    gnt_vld_s        = rst_n & (|req_s);
    o_icb_cmd_valid  = gnt_vld_s & ~cmd_full_s;
    o_icb_cmd_addr   = (gnt_s == M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    o_icb_cmd_read   = (gnt_s == M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
    o_icb_cmd_wdata  = (gnt_s == M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    m0_icb_cmd_ready = gnt_vld_s & (gnt_s == M0) & ~cmd_full_s & o_icb_cmd_ready;
    m1_icb_cmd_ready = gnt_vld_s & (gnt_s == M1) & ~cmd_full_s & o_icb_cmd_ready;
  end

  assign cmd_hs_s = o_icb_cmd_valid & o_icb_cmd_ready;

  // Response routing to the master at the FIFO head; blocked when nothing is outstanding.
  always_comb begin
    fifo_empty_s     = (count_s == {CW{1'b0}});
    m0_icb_rsp_valid = ~fifo_empty_s & (head_s == M0) & o_icb_rsp_valid;
    m1_icb_rsp_valid = ~fifo_empty_s & (head_s == M1) & o_icb_rsp_valid;
    m0_icb_rsp_rdata = o_icb_rsp_rdata;
    m1_icb_rsp_rdata = o_icb_rsp_rdata;
    if (fifo_empty_s) begin
      o_icb_rsp_ready = 1'b0;
    end else begin
      o_icb_rsp_ready = (head_s == M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    end
  end

  assign rsp_hs_s = o_icb_rsp_valid & o_icb_rsp_ready;

  // Round-robin history and stall lock; last_gnt resets to M1 so M0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= M1;
      lock_vld_r <= 1'b0;
      lock_id_r  <= M0;
    end else if (cmd_hs_s) begin
      last_gnt_r <= gnt_s;
      lock_vld_r <= 1'b0;
    end else if (o_icb_cmd_valid) begin
      lock_vld_r <= 1'b1;
      lock_id_r  <= gnt_s;
    end
  end

  icb_id_fifo #(
    .DEPTH (OUTS_DEPTH),
    .CW    (CW)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hs_s),
    .din   (gnt_s),
    .pop   (rsp_hs_s),
    .head  (head_s),
    .count (count_s),
    .full  (cmd_full_s)
  );

endmodule
